// File: rtl/rv_enc_pkg.sv
// rv_enc_pkg: shared constants and types for the RV32I instruction encoder.
// Holds the op-kind enum, major opcodes, the ALU code map shared with the
// core's decoder, funct3/funct7 values, the NOP word and FSM state type.
package rv_enc_pkg;

  typedef enum logic [2:0] {
    K_LW   = 3'd0,
    K_SW   = 3'd1,
    K_R    = 3'd2,
    K_BEQ  = 3'd3,
    K_IALU = 3'd4,
    K_JAL  = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LW_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam logic [31:0] NOP = 32'h00000013;

  function automatic logic alu_legal(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_AND) ||
           (op == ALU_OR)  || (op == ALU_SLT);
  endfunction

  function automatic logic [2:0] alu_f3(input logic [2:0] op);
    case (op)
      ALU_AND: return F3_AND;
      ALU_OR:  return F3_OR;
      ALU_SLT: return F3_SLT;
      default: return F3_ADD_SUB;
    endcase
  endfunction

endpackage

// File: rtl/rv_instr_packer.sv
// rv_instr_packer: purely combinational abstract-op -> RV32I word packer.
// Ports: kind/alu_op (3b), rd/rs1/rs2 (5b), imm (32b signed) in;
//        word (32b encoded instruction), illegal (op replaced by NOP) out.
// Config macro IMM_RANGE_CHECK_EN: when defined, immediates that do not fit
// their instruction field are rejected (NOP + illegal); otherwise they are
// truncated to the field bits.
module rv_instr_packer
  import rv_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  alu_op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

`ifdef IMM_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  // Fit tests: sign-extension bits must all match the field's top bit;
  // branch/jump offsets must also be even.
  logic fits12, fits13e, fits21e;
  assign fits12  = (imm[31:11] == {21{imm[11]}});
  assign fits13e = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign fits21e = (imm[31:20] == {12{imm[20]}}) && !imm[0];

  logic [2:0] f3;
  logic       alu_ok;
  assign f3     = alu_f3(alu_op);
  assign alu_ok = alu_legal(alu_op);

  always_comb begin
    word    = NOP;
    illegal = 1'b0;
    case (kind)
      K_LW: begin
        word    = {imm[11:0], rs1, F3_LW_SW, rd, OPC_LOAD};
        illegal = RANGE_CHECK && !fits12;
      end
      K_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_LW_SW, imm[4:0], OPC_STORE};
        illegal = RANGE_CHECK && !fits12;
      end
      K_R: begin
        word    = {(alu_op == ALU_SUB) ? F7_SUB : F7_BASE, rs2, rs1, f3, rd, OPC_OP};
        illegal = !alu_ok;
      end
      K_BEQ: begin
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OPC_BRANCH};
        illegal = RANGE_CHECK && !fits13e;
      end
      K_IALU: begin
        // I-type has no funct7 slot, so sub cannot be expressed.
        word    = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
        illegal = !alu_ok || (alu_op == ALU_SUB) || (RANGE_CHECK && !fits12);
      end
      K_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        illegal = RANGE_CHECK && !fits21e;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) word = NOP;
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: program loader that turns abstract ops received over
// valid/ready into RV32I words and writes them to imem at consecutive
// word addresses starting at BASE_ADDR.
// Ports: clk, rst_n (async, active-low), start (begin/restart load),
//        in_valid/in_ready handshake, in_kind/in_alu_op/in_rd/in_rs1/in_rs2/
//        in_imm/in_last op fields; mem_we/mem_addr/mem_wdata registered
//        write port; instr_count, done, err (sticky) status.
// Config macro IMM_RANGE_CHECK_EN (see rv_instr_packer): enables immediate
// range rejection.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_alu_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   instr_count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_e            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              err_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic [31:0] packed_word;
  logic        packed_illegal;

  rv_instr_packer u_packer (
    .kind    (in_kind),
    .alu_op  (in_alu_op),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (packed_word),
    .illegal (packed_illegal)
  );

  // Count is bumped on the accepting edge, so it reads CAP in the very
  // cycle the last slot's write is on the bus and acceptance stops there.
  logic full, accept, count_hits_cap;
  assign full           = (count_reg == CAP);
  assign in_ready       = (state_reg == ST_RUN) && !start && !full;
  assign accept         = in_valid && in_ready;
  assign count_hits_cap = ((count_reg + (ADDR_W+1)'(1)) == CAP);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN: begin
        if (start)
          state_next = ST_RUN;
        else if (accept && (in_last || count_hits_cap))
          state_next = ST_DONE;
      end
      ST_DONE: if (start) state_next = ST_RUN;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= BASE_ADDR;
      count_reg <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      we_reg    <= accept;
      if (start) begin
        // Address/data registers are left alone so a write already on the
        // bus completes at its old address.
        ptr_reg   <= BASE_ADDR;
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else if (accept) begin
        addr_reg  <= ptr_reg;
        wdata_reg <= packed_word;
        ptr_reg   <= ptr_reg + ADDR_W'(1);
        count_reg <= count_reg + (ADDR_W+1)'(1);
        err_reg   <= err_reg | packed_illegal;
      end
    end
  end

  assign mem_we      = we_reg;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign instr_count = count_reg;
  assign done        = (state_reg == ST_DONE);
  assign err         = err_reg;

endmodule
